pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard/sequencing controller for the ID->EX boundary of the SIMD AES pipeline.
//  Watches the instruction in ID and the one in EX and drives the PC, IF/ID and ID/EX controls.
//  Those controls are stall, flush, bubble insertion and hold.
//  Handles load-use hazards, taken-branch flushes and multicycle vector (AES round) ops.
//  It also keeps a saturating stall-cycle counter for performance readout.
// PARAMETERS
//  VEC_LAT   4      cycles a vector op occupies EX (>=1); VEC_LAT=1 => never holds
//  LOAD_SEL  2'b01  EX_MemToReg encoding meaning "writeback from data memory"
//  CNT_W     16     width of stall_cycles counter
// PORTS
//  clk           in   1      pipeline clock, all state updates on posedge
//  rst_n         in   1      asynchronous, active-low reset
//  ID_rs1        in   5      source reg 1 of instruction in ID
//  ID_rs2        in   5      source reg 2 of instruction in ID
//  ID_use_rs1    in   1      ID instruction reads rs1
//  ID_use_rs2    in   1      ID instruction reads rs2
//  ID_is_vec     in   1      ID instruction is a multicycle vector op
//  EX_rd         in   5      dest reg of instruction in EX
//  EX_RegWrite   in   1      EX instruction writes scalar RF
//  EX_MemToReg   in   2      EX writeback select
//  branch_taken  in   1      branch resolved taken in EX this cycle
//  stall_pc      out  1      hold PC
//  stall_ifid    out  1      hold IF/ID register
//  flush_ifid    out  1      zero IF/ID register (kill fetched instr)
//  bubble_idex   out  1      load ID/EX with all-zero controls (NOP)
//  hold_idex     out  1      ID/EX keeps its current contents
//  vec_busy      out  1      vector op is being held in EX
//  stall_cycles  out  CNT_W  count of cycles with stall_pc=1, saturating
// BEHAVIOUR
//  - Reset:
//    - Asynchronous: state=RUN, cnt=0, stall_cycles=0.
//    - All outputs are 0 while rst_n=0 and in the first RUN cycle absent hazards.
//  - FSM states: RUN, VBUSY. The outputs below are Mealy (combinational from state+inputs).
//  - RUN, priority high->low:
//    1) branch_taken=1: flush_ifid=1, bubble_idex=1, stall_pc=0.
//       Any load-use/vec issue in ID is dropped, since the ID instr is being killed.
//    2) Load-use:
//       - Condition: EX_RegWrite & EX_MemToReg==LOAD_SEL & EX_rd!=0 &
//         ((ID_use_rs1 & ID_rs1==EX_rd) | (ID_use_rs2 & ID_rs2==EX_rd)).
//       - Response: stall_pc=1, stall_ifid=1, bubble_idex=1 for exactly that cycle.
//       - The bubble removes the match next cycle; no state is needed.
//    3) ID_is_vec with no 1)/2):
//       - The op advances into EX normally at the next edge.
//       - If VEC_LAT>1: next state=VBUSY, cnt<=VEC_LAT-1.
//    4) Otherwise all control outputs are 0.
//  - VBUSY:
//    - Outputs: vec_busy=1, stall_pc=1, stall_ifid=1, hold_idex=1; flush/bubble=0.
//    - branch_taken and load-use are ignored (EX holds the vector op).
//    - cnt decrements each cycle; at cnt==1 next state=RUN.
//    - VBUSY lasts exactly VEC_LAT-1 cycles, so the vector op spends VEC_LAT cycles in EX.
//  - Invariants:
//    - hold_idex and bubble_idex are never both 1.
//    - flush_ifid and stall_ifid are never both 1.
//  - stall_cycles increments by 1 on each posedge where stall_pc=1.
//    It saturates at all-ones and never wraps.
//  - Reset mid-VBUSY: controller returns to RUN immediately; the pipeline is reset by the same rst_n.
// TESTING
//  1) Load-use:
//     - Stimulus: EX_RegWrite=1, EX_MemToReg=01, EX_rd=5, ID_rs1=5, ID_use_rs1=1.
//     - Response: that cycle stall_pc=stall_ifid=bubble_idex=1.
//     - Next cycle, with EX_RegWrite=0: all 0; stall_cycles=1.
//  2) Same as 1) with EX_rd=0, or with ID_use_rs1=0 -> no stall, all outputs 0.
//  3) VEC_LAT=4, ID_is_vec=1 at cycle t:
//     - Cycles t+1..t+3: vec_busy=stall_pc=stall_ifid=hold_idex=1.
//     - Cycle t+4: all 0; stall_cycles +=3.
//  4) branch_taken=1 together with a load-use match:
//     - Response: flush_ifid=1, bubble_idex=1, stall_pc=0, stall_ifid=0; stall_cycles unchanged.
//  5) rst_n=0 asserted at t+2 of test 3 (async, mid-clock):
//     - Response: outputs 0 immediately.
//     - After release, ID_is_vec=0 -> remains RUN, no stall.
//  6) CNT_W=4, force 20 load-use stalls -> stall_cycles=4'hF, and it holds at 4'hF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of the ID/EX observation signals and the pipeline control outputs
// exchanged between the pipeline datapath and pipe_hazard_ctrl.
//   master : pipeline side, drives ID/EX instruction info, receives controls
//   slave  : hazard controller, reads ID/EX info, drives controls + counter
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // ID stage instruction
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic             ID_use_rs1;
  logic             ID_use_rs2;
  logic             ID_is_vec;
  // EX stage instruction
  logic [4:0]       EX_rd;
  logic             EX_RegWrite;
  logic [1:0]       EX_MemToReg;
  logic             branch_taken;
  // pipeline controls
  logic             stall_pc;
  logic             stall_ifid;
  logic             flush_ifid;
  logic             bubble_idex;
  logic             hold_idex;
  logic             vec_busy;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_is_vec,
           EX_rd, EX_RegWrite, EX_MemToReg, branch_taken,
    input  stall_pc, stall_ifid, flush_ifid, bubble_idex, hold_idex,
           vec_busy, stall_cycles
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_is_vec,
           EX_rd, EX_RegWrite, EX_MemToReg, branch_taken,
    output stall_pc, stall_ifid, flush_ifid, bubble_idex, hold_idex,
           vec_busy, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the ID->EX boundary of the SIMD AES
// pipeline. Detects load-use hazards, flushes on taken branches and holds
// the pipeline while a multicycle vector op occupies EX. Also keeps a
// saturating count of PC-stall cycles for performance readout.
//   clk   : pipeline clock
//   rst_n : asynchronous active-low reset
//   bus   : pipe_hazard_ctrl_if.slave (ID/EX info in, controls out)
// Parameters:
//   VEC_LAT  : cycles a vector op occupies EX (>=1; 1 means never hold)
//   LOAD_SEL : EX_MemToReg code for "writeback from data memory"
//   CNT_W    : width of stall_cycles (must match the interface)
module pipe_hazard_ctrl #(
  parameter int         VEC_LAT  = 4,
  parameter logic [1:0] LOAD_SEL = 2'b01,
  parameter int         CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_hazard_ctrl_if.slave     bus
);

  localparam int VC_W = (VEC_LAT > 1) ? $clog2(VEC_LAT) : 1;

  typedef enum logic {RUN, VBUSY} state_t;

  state_t            state, state_nx;
  logic [VC_W-1:0]   cnt, cnt_nx;
  logic [CNT_W-1:0]  stall_cnt;
  logic              load_use;
  logic              stall_pc, stall_ifid, flush_ifid;
  logic              bubble_idex, hold_idex, vec_busy;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = bus.EX_RegWrite && (bus.EX_MemToReg == LOAD_SEL) &&
                    (bus.EX_rd != 5'd0) &&
                    ((bus.ID_use_rs1 && (bus.ID_rs1 == bus.EX_rd)) ||
                     (bus.ID_use_rs2 && (bus.ID_rs2 == bus.EX_rd)));

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    hold_idex   = 1'b0;
    vec_busy    = 1'b0;
    // Controls are forced quiet while reset is held, whatever ID/EX show.
    if (rst_n) begin
      unique case (state)
        RUN: begin
          if (bus.branch_taken) begin
            // The ID instruction is being killed, so its hazards don't matter.
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
          end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
          end else if (bus.ID_is_vec && (VEC_LAT > 1)) begin
            // Op enters EX at this edge; EX is then held VEC_LAT-1 more cycles.
            state_nx = VBUSY;
            cnt_nx   = VC_W'(VEC_LAT - 1);
          end
        end
        VBUSY: begin
          vec_busy   = 1'b1;
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          hold_idex  = 1'b1;
          cnt_nx     = cnt - 1'b1;
          if (cnt == VC_W'(1)) state_nx = RUN;
        end
        default: state_nx = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (stall_pc && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.stall_pc     = stall_pc;
  assign bus.stall_ifid   = stall_ifid;
  assign bus.flush_ifid   = flush_ifid;
  assign bus.bubble_idex  = bubble_idex;
  assign bus.hold_idex    = hold_idex;
  assign bus.vec_busy     = vec_busy;
  assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a table of single-cycle vectors
// plus hand-written sequences for the vector hold, mid-hold reset and
// counter saturation (second instance with a 4-bit counter).
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       is_vec;
    logic [4:0] rd;
    logic       rw;
    logic [1:0] m2r;
    logic       br;
  } in_t;

  // {stall_pc, stall_ifid, flush_ifid, bubble_idex, hold_idex, vec_busy}
  typedef logic [5:0] out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  localparam out_t O_NONE  = 6'b000000;
  localparam out_t O_LOAD  = 6'b110100;
  localparam out_t O_FLUSH = 6'b001100;
  localparam out_t O_BUSY  = 6'b110011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) a_if ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  b_if ();

  pipe_hazard_ctrl #(.VEC_LAT(4), .LOAD_SEL(2'b01), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  pipe_hazard_ctrl #(.VEC_LAT(4), .LOAD_SEL(2'b01), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  int total = 0;
  int bad = 0;
  int m_cnt = 0;          // model of dut_a stall_cycles
  out_t sb_q[$];          // expected outputs, pushed on drive, popped on sample
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic use1, input logic use2, input logic is_vec,
                             input logic [4:0] rd, input logic rw,
                             input logic [1:0] m2r, input logic br);
    in_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2; v.is_vec = is_vec;
    v.rd = rd; v.rw = rw; v.m2r = m2r; v.br = br;
    return v;
  endfunction

  task automatic drive_a(input in_t v);
    a_if.ID_rs1 = v.rs1;       a_if.ID_rs2 = v.rs2;
    a_if.ID_use_rs1 = v.use1;  a_if.ID_use_rs2 = v.use2;
    a_if.ID_is_vec = v.is_vec; a_if.EX_rd = v.rd;
    a_if.EX_RegWrite = v.rw;   a_if.EX_MemToReg = v.m2r;
    a_if.branch_taken = v.br;
  endtask

  task automatic drive_b(input in_t v);
    b_if.ID_rs1 = v.rs1;       b_if.ID_rs2 = v.rs2;
    b_if.ID_use_rs1 = v.use1;  b_if.ID_use_rs2 = v.use2;
    b_if.ID_is_vec = v.is_vec; b_if.EX_rd = v.rd;
    b_if.EX_RegWrite = v.rw;   b_if.EX_MemToReg = v.m2r;
    b_if.branch_taken = v.br;
  endtask

  function automatic out_t act_a();
    return {a_if.stall_pc, a_if.stall_ifid, a_if.flush_ifid,
            a_if.bubble_idex, a_if.hold_idex, a_if.vec_busy};
  endfunction

  // Pop one expectation and compare outputs, counter and invariants.
  task automatic sample(input string name);
    out_t e;
    if (sb_q.size() == 0) begin
      check({name, " sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check({name, " ctl"}, 32'(act_a()), 32'(e));
    check({name, " cnt"}, 32'(a_if.stall_cycles), 32'(m_cnt));
    if (a_if.hold_idex && a_if.bubble_idex) check({name, " inv_hb"}, 32'd1, 32'd0);
    if (a_if.flush_ifid && a_if.stall_ifid) check({name, " inv_fs"}, 32'd1, 32'd0);
    if (e[5] && m_cnt < 32'hFFFF) m_cnt++;
  endtask

  task automatic step(input string name, input in_t v, input out_t e);
    @(posedge clk);
    #1;
    drive_a(v);
    sb_q.push_back(e);
    @(negedge clk);
    sample(name);
  endtask

  in_t idle, lu, lu_br;
  int  nb;

  initial begin
    idle  = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    lu    = mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0);
    lu_br = mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b1);
    drive_a(lu_br);   // busy inputs while in reset: outputs must still be 0
    drive_b(idle);

    tbl[0]  = '{"idle",        idle, O_NONE};
    tbl[1]  = '{"lu_rs1",      lu, O_LOAD};
    tbl[2]  = '{"after_lu",    mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 2'b01, 1'b0), O_NONE};
    tbl[3]  = '{"rd_zero",     mk(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 2'b01, 1'b0), O_NONE};
    tbl[4]  = '{"no_use_rs1",  mk(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0), O_NONE};
    tbl[5]  = '{"lu_rs2",      mk(5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 2'b01, 1'b0), O_LOAD};
    tbl[6]  = '{"m2r_alu",     mk(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 2'b00, 1'b0), O_NONE};
    tbl[7]  = '{"m2r_10",      mk(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 2'b10, 1'b0), O_NONE};
    tbl[8]  = '{"br_over_lu",  lu_br, O_FLUSH};
    tbl[9]  = '{"br_only",     mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1), O_FLUSH};
    tbl[10] = '{"rs2_nouse",   mk(5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 2'b01, 1'b0), O_NONE};
    tbl[11] = '{"no_regwrite", mk(5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 2'b01, 1'b0), O_NONE};

    // Reset state
    #12;
    check("rst ctl", 32'(act_a()), 32'(O_NONE));
    check("rst cnt", 32'(a_if.stall_cycles), 32'd0);
    drive_a(idle);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle vectors
    for (int k = 0; k < 12; k++) step(tbl[k].name, tbl[k].i, tbl[k].o);

    // Vector hold: three held cycles, hazards on the inputs are ignored
    step("vec_t",   mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 2'b00, 1'b0), O_NONE);
    step("vec_t+1", lu_br, O_BUSY);
    step("vec_t+2", lu, O_BUSY);
    step("vec_t+3", idle, O_BUSY);
    step("vec_t+4", idle, O_NONE);

    // Branch and load-use both beat a vector op in ID
    step("vec_br",   mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 2'b00, 1'b1), O_FLUSH);
    step("vec_br+1", idle, O_NONE);
    step("vec_lu",   mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 2'b01, 1'b0), O_LOAD);
    step("vec_lu+1", idle, O_NONE);

    // Reset in the middle of a vector hold
    step("rvec_t",   mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 2'b00, 1'b0), O_NONE);
    step("rvec_t+1", idle, O_BUSY);
    @(posedge clk);
    #1;
    drive_a(lu_br);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst ctl", 32'(act_a()), 32'(O_NONE));
    check("midrst cnt", 32'(a_if.stall_cycles), 32'd0);
    m_cnt = 0;
    drive_a(idle);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst1", idle, O_NONE);
    step("post_rst2", idle, O_NONE);

    // Counter saturation on the 4-bit instance
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      drive_b(lu);
      @(negedge clk);
      check("sat stall_pc", 32'(b_if.stall_pc), 32'd1);
      check("sat cnt", 32'(b_if.stall_cycles), 32'(nb));
      if (nb < 15) nb++;
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      drive_b(idle);
      @(negedge clk);
      check("sat hold", 32'(b_if.stall_cycles), 32'hF);
    end

    check("sb drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
